// File: rtl/alu_arbiter.sv
// Two-port round-robin front end for one shared combinational alu.
// Operands are registered toward the alu; multiply ops get MUL_WAIT extra settle cycles.
module alu_arbiter #(
  parameter int WIDTH    = 32,
  parameter int MUL_WAIT = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [5:0]       req0_alufn,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [5:0]       req1_alufn,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [5:0]       alu_alufn,
  input  logic [WIDTH-1:0] alu_out,
  input  logic             alu_z,
  input  logic             alu_n,
  input  logic             alu_v,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_out,
  output logic             rsp_z,
  output logic             rsp_n,
  output logic             rsp_v,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  localparam logic [3:0] MUL_CNT = 4'(MUL_WAIT);

  state_t     state;
  logic       ptr;
  logic       op_id;
  logic [3:0] cnt;

  logic       grant0;
  logic       grant1;
  logic [5:0] sel_fn;
  logic       sel_mul;

  // Pointer only matters when both requesters contend.
  assign grant0  = req0_valid & (~req1_valid | ~ptr);
  assign grant1  = req1_valid & (~req0_valid |  ptr);
  assign req0_ready = (state == IDLE) & grant0;
  assign req1_ready = (state == IDLE) & grant1;

  assign sel_fn  = grant1 ? req1_alufn : req0_alufn;
  assign sel_mul = (sel_fn[5:4] == 2'b00) & sel_fn[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      ptr       <= 1'b0;
      op_id     <= 1'b0;
      cnt       <= 4'd0;
      alu_a     <= '0;
      alu_b     <= '0;
      alu_alufn <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= 1'b0;
      rsp_out   <= '0;
      rsp_z     <= 1'b0;
      rsp_n     <= 1'b0;
      rsp_v     <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grant0 | grant1) begin
            alu_a     <= grant1 ? req1_a : req0_a;
            alu_b     <= grant1 ? req1_b : req0_b;
            alu_alufn <= sel_fn;
            op_id     <= grant1;
            ptr       <= ~grant1;
            cnt       <= sel_mul ? MUL_CNT : 4'd0;
            busy      <= 1'b1;
            state     <= EXEC;
          end
        end
        EXEC: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            rsp_out   <= alu_out;
            rsp_z     <= alu_z;
            rsp_n     <= alu_n;
            rsp_v     <= alu_v;
            rsp_id    <= op_id;
            rsp_valid <= 1'b1;
            state     <= RESP;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter with a small behavioural alu hanging off the alu_* ports.
module tb_alu_arbiter;

  localparam int WIDTH    = 32;
  localparam int MUL_WAIT = 2;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             req0_valid = 1'b0, req1_valid = 1'b0;
  logic             req0_ready, req1_ready;
  logic [WIDTH-1:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic [5:0]       req0_alufn = '0, req1_alufn = '0;
  logic [WIDTH-1:0] alu_a, alu_b, alu_out;
  logic [5:0]       alu_alufn;
  logic             alu_z, alu_n, alu_v;
  logic             rsp_valid, rsp_id, rsp_z, rsp_n, rsp_v, busy;
  logic             rsp_ready = 1'b0;
  logic [WIDTH-1:0] rsp_out;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  alu_arbiter #(.WIDTH(WIDTH), .MUL_WAIT(MUL_WAIT)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_alufn(req0_alufn),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_alufn(req1_alufn),
    .alu_a(alu_a), .alu_b(alu_b), .alu_alufn(alu_alufn),
    .alu_out(alu_out), .alu_z(alu_z), .alu_n(alu_n), .alu_v(alu_v),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_out(rsp_out),
    .rsp_z(rsp_z), .rsp_n(rsp_n), .rsp_v(rsp_v), .busy(busy)
  );

  // Behavioural alu: add, sub, mul low, mul high; anything else is a bitwise AND.
  logic [63:0] prod;
  always_comb begin
    prod    = 64'(alu_a) * 64'(alu_b);
    alu_v   = 1'b0;
    case (alu_alufn)
      6'b000000: begin
        alu_out = alu_a + alu_b;
        alu_v   = (alu_a[31] == alu_b[31]) && (alu_out[31] != alu_a[31]);
      end
      6'b000001: begin
        alu_out = alu_a - alu_b;
        alu_v   = (alu_a[31] != alu_b[31]) && (alu_out[31] != alu_a[31]);
      end
      6'b000010: alu_out = prod[31:0];
      6'b000011: alu_out = prod[63:32];
      default:   alu_out = alu_a & alu_b;
    endcase
    alu_z = (alu_out == '0);
    alu_n = alu_out[31];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    rsp_ready  = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Issues one op, returns number of EXEC cycles seen before rsp_valid.
  task automatic issue(input bit id, input logic [31:0] a, input logic [31:0] b,
                       input logic [5:0] fn, output int exec);
    @(negedge clk);
    if (id) begin
      req1_a = a; req1_b = b; req1_alufn = fn; req1_valid = 1'b1;
    end else begin
      req0_a = a; req0_b = b; req0_alufn = fn; req0_valid = 1'b1;
    end
    #1;
    chk("req_ready", 32'(id ? req1_ready : req0_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    exec = 0;
    while (!rsp_valid && exec < 40) begin
      @(posedge clk);
      exec++;
      @(negedge clk);
    end
  endtask

  typedef struct {
    bit          id;
    logic [31:0] a;
    logic [31:0] b;
    logic [5:0]  fn;
    logic [31:0] exp_out;
    bit          exp_z;
    bit          exp_n;
    bit          exp_v;
    int          exp_exec;
  } vec_t;

  vec_t vecs[8];
  int   exec;
  logic [31:0] held;
  bit   ids[$];
  logic [31:0] outs[$];

  initial begin
    vecs[0] = '{1'b0, 32'd5,        32'd7,        6'b000000, 32'd12,         1'b0, 1'b0, 1'b0, 1};
    vecs[1] = '{1'b1, 32'd5,        32'd5,        6'b000001, 32'd0,          1'b1, 1'b0, 1'b0, 1};
    vecs[2] = '{1'b0, 32'd3,        32'd4,        6'b000010, 32'd12,         1'b0, 1'b0, 1'b0, 3};
    vecs[3] = '{1'b1, 32'h0001_0000, 32'h0001_0000, 6'b000011, 32'd1,        1'b0, 1'b0, 1'b0, 3};
    vecs[4] = '{1'b0, 32'h7fff_ffff, 32'd1,        6'b000000, 32'h8000_0000, 1'b0, 1'b1, 1'b1, 1};
    vecs[5] = '{1'b1, 32'd3,        32'd5,        6'b000001, 32'hffff_fffe, 1'b0, 1'b1, 1'b0, 1};
    vecs[6] = '{1'b0, 32'h0000_00f0, 32'h0000_003c, 6'b010010, 32'h0000_0030, 1'b0, 1'b0, 1'b0, 1};
    vecs[7] = '{1'b1, 32'h0000_00ff, 32'h0000_000f, 6'b000110, 32'h0000_000f, 1'b0, 1'b0, 1'b0, 3};

    #2;
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset_alu_a", alu_a, 32'd0);
    chk("reset_rsp_out", rsp_out, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      issue(vecs[i].id, vecs[i].a, vecs[i].b, vecs[i].fn, exec);
      chk($sformatf("v%0d_exec", i), 32'(exec), 32'(vecs[i].exp_exec));
      chk($sformatf("v%0d_out", i), rsp_out, vecs[i].exp_out);
      chk($sformatf("v%0d_zn_v", i), {29'd0, rsp_z, rsp_n, rsp_v},
          {29'd0, vecs[i].exp_z, vecs[i].exp_n, vecs[i].exp_v});
      chk($sformatf("v%0d_id", i), 32'(rsp_id), 32'(vecs[i].id));
      rsp_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rsp_ready = 1'b0;
      chk($sformatf("v%0d_idle", i), {30'd0, busy, rsp_valid}, 32'd0);
      chk($sformatf("v%0d_hold", i), rsp_out, vecs[i].exp_out);
    end

    // Contention from reset: ids must alternate starting with requester 0.
    do_reset();
    req0_a = 32'd1;  req0_b = 32'd1;  req0_alufn = 6'b000000;
    req1_a = 32'd10; req1_b = 32'd10; req1_alufn = 6'b000000;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    rsp_ready  = 1'b1;
    for (int c = 0; c < 60 && ids.size() < 4; c++) begin
      @(negedge clk);
      if (rsp_valid) begin
        ids.push_back(rsp_id);
        outs.push_back(rsp_out);
      end
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    chk("rr_count", 32'(ids.size()), 32'd4);
    for (int k = 0; k < ids.size(); k++) begin
      chk($sformatf("rr_id%0d", k), 32'(ids[k]), 32'(k % 2));
      chk($sformatf("rr_out%0d", k), outs[k], (k % 2) ? 32'd20 : 32'd2);
    end
    rsp_ready = 1'b0;

    // Backpressure: response held for 5 cycles with a competing valid.
    do_reset();
    issue(1'b0, 32'd100, 32'd23, 6'b000000, exec);
    chk("bp_valid", 32'(rsp_valid), 32'd1);
    held = rsp_out;
    req1_a = 32'd1; req1_b = 32'd2; req1_alufn = 6'b000000;
    req1_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      @(negedge clk);
      chk("bp_out_stable", rsp_out, 32'd123);
      chk("bp_ready_low", {30'd0, req0_ready, req1_ready}, 32'd0);
      chk("bp_busy_valid", {30'd0, busy, rsp_valid}, 32'd3);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("bp_release_idle", 32'(busy), 32'd0);
    chk("bp_release_held", rsp_out, held);
    req1_valid = 1'b0;
    rsp_ready  = 1'b0;

    // Reset mid-EXEC on a multiply: aborts immediately, never responds.
    do_reset();
    @(negedge clk);
    req0_a = 32'd6; req0_b = 32'd7; req0_alufn = 6'b000010; req0_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req0_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("abort_pre_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("abort_alu_a", alu_a, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    rsp_ready = 1'b1;
    held = 32'd0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (rsp_valid) held = held + 32'd1;
    end
    chk("abort_no_rsp", held, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
